nios_core_buffer_reader: RTL and testbench

Avalon-MM read master that drains a word range from the on-chip data buffer and presents it as an Avalon-ST source, for example toward the audio DAC FIFO or the VGA line feeder. The Nios II programs start address, length and mode through a 4-register CSR slave. The block then streams the words out with backpressure, optionally looping, and raises `done`/`irq` at the end. It connects directly to the buffer's single-port slave, which has a fixed read latency and no waitrequest.

---
 rtl/nios_core_buffer_reader_pkg.sv | 15 +
 rtl/nios_core_buffer_reader_fifo.sv | 40 ++++
 rtl/nios_core_buffer_reader.sv | 119 +++++++++++
 tb/tb_nios_core_buffer_reader.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/nios_core_buffer_reader_pkg.sv
// nios_core_buffer_reader_pkg: CSR map, control/status bit positions and FSM encoding
package nios_core_buffer_reader_pkg;
  localparam logic [1:0] CSR_START   = 2'd0;
  localparam logic [1:0] CSR_LENGTH  = 2'd1;
  localparam logic [1:0] CSR_CONTROL = 2'd2;
  localparam logic [1:0] CSR_STATUS  = 2'd3;
  localparam int CTRL_GO     = 0;
  localparam int CTRL_LOOP   = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_STOP   = 3;
  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_REMAIN = 16;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} state_t;
endpackage

// File: rtl/nios_core_buffer_reader_fifo.sv
// nios_core_buffer_reader_fifo: show-ahead synchronous FIFO with flush
module nios_core_buffer_reader_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          push,
  input  logic [DATA_W-1:0]             din,
  input  logic                          pop,
  input  logic                          flush,
  output logic [DATA_W-1:0]             dout,
  output logic [$clog2(FIFO_DEPTH):0]   count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push && !flush;
  assign do_pop = pop && count != '0 && !flush;
  assign dout = count != '0 ? mem[rd_ptr] : '0;
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/nios_core_buffer_reader.sv
// nios_core_buffer_reader: CSR-programmed Avalon-MM buffer reader streaming words to an Avalon-ST source
module nios_core_buffer_reader
  import nios_core_buffer_reader_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          csr_address,
  input  logic                csr_write,
  input  logic [31:0]         csr_writedata,
  input  logic                csr_read,
  output logic [31:0]         csr_readdata,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_chipselect,
  output logic                m_write,
  output logic [DATA_W/8-1:0] m_byteenable,
  input  logic [DATA_W-1:0]   m_readdata,
  output logic [DATA_W-1:0]   src_data,
  output logic                src_valid,
  input  logic                src_ready,
  output logic                irq
);
  localparam int CW = $clog2(FIFO_DEPTH);
  state_t state, state_n;
  logic [ADDR_W-1:0] start_reg, start_w, addr;
  logic [ADDR_W:0] length_reg, len_w, remaining;
  logic loop_en, irq_en, done;
  logic [READ_LATENCY-1:0] pipe;
  logic [CW:0] outstanding, count;
  logic ctrl_wr, go_hit, stop_hit, credit, issue, last, drained, done_set, done_clr;
  logic [31:0] status_word, control_word, rd_mux;
  logic csr_unused;
  assign csr_unused = &{1'b0, csr_writedata};
  assign ctrl_wr = csr_write && csr_address == CSR_CONTROL;
  assign go_hit = ctrl_wr && csr_writedata[CTRL_GO] && state == IDLE;
  assign stop_hit = ctrl_wr && csr_writedata[CTRL_STOP] && (state == RUN || state == DRAIN);
  assign credit = ({1'b0, outstanding} + {1'b0, count}) < (CW+2)'(FIFO_DEPTH);
  assign issue = state == RUN && credit && !stop_hit;
  assign last = issue && remaining == (ADDR_W+1)'(1);
  assign drained = outstanding == '0 && count == '0;
  assign done_set = (go_hit && length_reg == '0) || (state == DRAIN && !stop_hit && drained);
  assign done_clr = csr_write && csr_address == CSR_STATUS && csr_writedata[STAT_DONE];
  assign status_word = (32'(remaining) << STAT_REMAIN) | (32'(done) << STAT_DONE) | (32'(state != IDLE) << STAT_BUSY);
  assign control_word = (32'(loop_en) << CTRL_LOOP) | (32'(irq_en) << CTRL_IRQ_EN);
  assign rd_mux = csr_address == CSR_START ? 32'(start_reg) :
                  csr_address == CSR_LENGTH ? 32'(length_reg) :
                  csr_address == CSR_CONTROL ? control_word : status_word;
  assign m_address = addr;
  assign m_chipselect = issue;
  assign m_write = 1'b0;
  assign m_byteenable = '1;
  assign src_valid = count != '0;
  assign irq = done && irq_en;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = go_hit && length_reg != '0 ? RUN : IDLE;
      RUN:     state_n = stop_hit ? FLUSH : (last && !loop_en) ? DRAIN : RUN;
      DRAIN:   state_n = stop_hit ? FLUSH : drained ? IDLE : DRAIN;
      FLUSH:   state_n = outstanding == '0 ? IDLE : FLUSH;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      start_reg <= '0;
      length_reg <= '0;
      start_w <= '0;
      len_w <= '0;
      addr <= '0;
      remaining <= '0;
      loop_en <= 1'b0;
      irq_en <= 1'b0;
      done <= 1'b0;
      pipe <= '0;
      outstanding <= '0;
      csr_readdata <= '0;
    end else begin
      state <= state_n;
      pipe <= READ_LATENCY'({pipe, issue});
      outstanding <= outstanding + (CW+1)'(issue) - (CW+1)'(pipe[READ_LATENCY-1]);
      done <= done_set || (done && !done_clr);
      if (csr_write && csr_address == CSR_START) start_reg <= csr_writedata[ADDR_W-1:0];
      if (csr_write && csr_address == CSR_LENGTH) length_reg <= csr_writedata[ADDR_W:0];
      if (ctrl_wr) begin
        loop_en <= csr_writedata[CTRL_LOOP];
        irq_en <= csr_writedata[CTRL_IRQ_EN];
      end
      if (go_hit) begin
        start_w <= start_reg;
        len_w <= length_reg;
        addr <= start_reg;
        remaining <= length_reg;
      end else if (issue) begin
        addr <= (last && loop_en) ? start_w : addr + ADDR_W'(1);
        remaining <= (last && loop_en) ? len_w : remaining - (ADDR_W+1)'(1);
      end
      if (csr_read) csr_readdata <= rd_mux;
    end
  end
  nios_core_buffer_reader_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(pipe[READ_LATENCY-1]),
    .din(m_readdata),
    .pop(src_valid && src_ready),
    .flush(state == FLUSH || stop_hit),
    .dout(src_data),
    .count(count)
  );
endmodule

// File: tb/tb_nios_core_buffer_reader.sv
// tb_nios_core_buffer_reader: randomized self-checking bench against a sequence-level model
module tb_nios_core_buffer_reader;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int RL = 1;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] csr_address = '0;
  logic csr_write = 1'b0;
  logic [31:0] csr_writedata = '0;
  logic csr_read = 1'b0;
  logic [31:0] csr_readdata;
  logic [ADDR_W-1:0] m_address;
  logic m_chipselect, m_write;
  logic [DATA_W/8-1:0] m_byteenable;
  logic [DATA_W-1:0] m_readdata = '0;
  logic [DATA_W-1:0] src_data;
  logic src_valid;
  logic src_ready = 1'b1;
  logic irq;
  logic [31:0] bufmem [1024];
  int n_chk = 0, n_err = 0;
  int n_iss = 0, n_xfer = 0, exp_start = 0, exp_len = 0;
  logic tracking = 1'b0, rnd_ready = 1'b0, stall_q = 1'b0;
  logic [DATA_W-1:0] data_q = '0;
  logic [31:0] st;
  nios_core_buffer_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(RL), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .csr_address(csr_address), .csr_write(csr_write), .csr_writedata(csr_writedata),
    .csr_read(csr_read), .csr_readdata(csr_readdata),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write(m_write),
    .m_byteenable(m_byteenable), .m_readdata(m_readdata),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready), .irq(irq)
  );
  always #5 clk = ~clk;
  always @(posedge clk) m_readdata <= m_chipselect ? bufmem[m_address] : 32'hdead_beef;
  always @(posedge clk) begin
    #1;
    if (rnd_ready) src_ready = 1'($urandom_range(0, 1));
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [ADDR_W-1:0] exp_addr(input int n);
    return ADDR_W'((exp_start + (exp_len == 0 ? 0 : n % exp_len)) % 1024);
  endfunction
  always @(negedge clk) begin
    if (tracking) begin
      if (m_chipselect) begin
        check("read_addr", m_address, exp_addr(n_iss));
        n_iss++;
      end
      if (stall_q) begin
        check("hold_valid", src_valid, 1);
        check("hold_data", src_data, data_q);
      end
      if (src_valid && src_ready) begin
        check("stream_data", src_data, bufmem[exp_addr(n_xfer)]);
        n_xfer++;
      end
      check("credit_bound", (n_iss - n_xfer) <= DEPTH, 1);
      stall_q = src_valid && !src_ready;
      data_q = src_data;
    end else stall_q = 1'b0;
  end
  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    csr_address = a;
    csr_writedata = d;
    csr_write = 1'b1;
    @(posedge clk); #1;
    csr_write = 1'b0;
  endtask
  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    csr_address = a;
    csr_read = 1'b1;
    @(posedge clk); #1;
    csr_read = 1'b0;
    d = csr_readdata;
  endtask
  task automatic start_run(input int s, input int l, input logic [31:0] ctl);
    csr_wr(2'd3, 32'h2);
    csr_wr(2'd0, 32'(s));
    csr_wr(2'd1, 32'(l));
    exp_start = s;
    exp_len = l;
    n_iss = 0;
    n_xfer = 0;
    tracking = 1'b1;
    csr_wr(2'd2, ctl | 32'h1);
  endtask
  task automatic wait_idle(output logic [31:0] s);
    s = '1;
    for (int i = 0; i < 4000 && s[0]; i++) csr_rd(2'd3, s);
    check("idle_timeout", s[0], 0);
  endtask
  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 1024; i++) bufmem[i] = 32'(i);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    check("rst_cs", m_chipselect, 0);
    check("rst_valid", src_valid, 0);
    check("rst_irq", irq, 0);
    check("rst_write", m_write, 0);
    check("rst_be", m_byteenable, 4'hf);
    csr_rd(2'd3, st);
    check("rst_status", st, 0);
    // basic run: contiguous stream after first word, then done
    start_run(32'h10, 8, 32'h0);
    check("first_cs", m_chipselect, 1);
    @(posedge clk); #1;
    check("valid_latency_early", src_valid, 0);
    @(posedge clk); #1;
    check("valid_latency", src_valid, 1);
    check("first_word", src_data, 32'h10);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      check("contig_valid", src_valid, 1);
    end
    wait_idle(st);
    check("basic_xfer", n_xfer, 8);
    check("basic_iss", n_iss, 8);
    check("basic_done", st[1], 1);
    check("basic_remain", st[26:16], 0);
    check("basic_irq_off", irq, 0);
    // wrap around the top of the address space, with interrupt
    start_run(32'h3fe, 4, 32'h4);
    wait_idle(st);
    check("wrap_xfer", n_xfer, 4);
    check("wrap_irq", irq, 1);
    csr_wr(2'd3, 32'h2);
    check("wrap_irq_clr", irq, 0);
    // loop mode then stop
    start_run(32'h100, 3, 32'h2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      check("loop_contig", src_valid, 1);
      @(posedge clk); #1;
    end
    csr_wr(2'd2, 32'h8 | 32'h2);
    check("stop_valid", src_valid, 0);
    check("stop_cs", m_chipselect, 0);
    check("loop_progress", n_xfer > 12, 1);
    tracking = 1'b0;
    wait_idle(st);
    check("stop_done", st[1], 0);
    check("stop_busy", st[0], 0);
    // zero length
    csr_wr(2'd1, 32'h0);
    n_iss = 0;
    exp_len = 0;
    tracking = 1'b1;
    check("len0_irq_before", irq, 0);
    csr_wr(2'd2, 32'h1 | 32'h4);
    check("len0_irq", irq, 1);
    repeat (5) @(posedge clk);
    #1;
    check("len0_no_read", n_iss, 0);
    csr_rd(2'd3, st);
    check("len0_status", st[1:0], 2'b10);
    csr_wr(2'd3, 32'h2);
    check("len0_irq_clr", irq, 0);
    // random backpressure over the full buffer
    for (int i = 0; i < 1024; i++) bufmem[i] = $urandom;
    rnd_ready = 1'b1;
    start_run(int'($urandom_range(0, 1023)), 1024, 32'h0);
    wait_idle(st);
    rnd_ready = 1'b0;
    @(posedge clk); #1;
    src_ready = 1'b1;
    check("rand_xfer", n_xfer, 1024);
    check("rand_iss", n_iss, 1024);
    check("rand_done", st[1], 1);
    // reset mid-run
    start_run(0, 1000, 32'h4);
    repeat (20) @(posedge clk);
    #1;
    tracking = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midrst_cs", m_chipselect, 0);
    check("midrst_valid", src_valid, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    csr_rd(2'd3, st);
    check("midrst_status", st, 0);
    csr_rd(2'd1, st);
    check("midrst_length", st, 0);
    start_run(32'h20, 5, 32'h0);
    wait_idle(st);
    check("restart_xfer", n_xfer, 5);
    check("restart_done", st[1], 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
